regfile_port_arbiter: RTL
=========================

Name: regfile_port_arbiter

Overview:
- Shares the single write port and two read ports of the 32x32 register file between two requesters (req0, req1).
- Uses round-robin arbitration with a valid/ready handshake. The requesters are the display/touch-input path and a test sequencer.
- After reset, or on a software clear, it runs an init sequence that writes INIT_VALUE to all 32 registers before accepting requests.
- Sits between the requesters and the regfile instance and drives all of its control/address/data inputs.

Parameters:
INIT_VALUE  32'h0000_0000  value written to every register during INIT
INIT_EN     1              1 = run INIT after reset/clear; 0 = go directly to RUN

Ports:
clk          in   1   clock
resetn       in   1   synchronous reset, active-low
clear_req    in   1   one-cycle pulse; re-runs INIT from RUN
init_done    out  1   high while in RUN
reqN_valid   in   1   (N=0,1) request valid
reqN_ready   out  1   grant to requester N this cycle
reqN_we      in   1   transaction includes a write
reqN_be      in   4   byte enables for the write
reqN_ren     in   2   read enables, bit0 = port1, bit1 = port2
reqN_raddr1  in   5   read address 1
reqN_raddr2  in   5   read address 2
reqN_waddr   in   5   write address
reqN_wdata   in   32  write data
rspN_valid   out  1   one-cycle pulse: read data for requester N is valid
rspN_rdata1  out  32  captured read data, port 1
rspN_rdata2  out  32  captured read data, port 2
rf_wen       out  4   to regfile wen
rf_ren       out  2   to regfile ren
rf_raddr1    out  5   to regfile raddr1
rf_raddr2    out  5   to regfile raddr2
rf_waddr     out  5   to regfile waddr
rf_wdata     out  32  to regfile wdata
rf_rdata1    in   32  from regfile rdata1 (combinational read)
rf_rdata2    in   32  from regfile rdata2 (combinational read)

Behaviour:
- States: INIT, RUN.
- Reset (resetn low at posedge):
  - State goes to INIT (RUN if INIT_EN=0); init_cnt=0; last_grant=1.
  - rspN_valid=0, rspN_rdata*=0.
  - While resetn is low: rf_wen=0, rf_ren=0, reqN_ready=0.
- INIT:
  - Each cycle: rf_wen=4'hF, rf_waddr=init_cnt, rf_wdata=INIT_VALUE, rf_ren=0, both ready=0.
  - init_cnt increments each cycle. After the cycle with init_cnt=31, state goes to RUN and init_cnt goes to 0.
  - INIT therefore takes exactly 32 cycles; init_done=0 throughout.
  - clear_req is ignored in INIT.
- RUN, arbitration (combinational, one transaction per cycle):
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant updates on every grant.
  - reqN_ready = grant to N; a transaction is accepted when valid && ready.
- RUN, regfile drive:
  - Granted request drives rf_raddr1, rf_raddr2, rf_waddr, rf_wdata.
  - rf_ren = reqN_ren.
  - rf_wen = reqN_we ? reqN_be : 4'h0.
  - No grant: rf_wen=0, rf_ren=0, addresses/data hold the previous values.
- Response:
  - Accepted transaction with ren != 0: rf_rdata1/2 are captured into rspN_rdata1/2 at the accepting edge, and rspN_valid pulses high the following cycle (latency 1).
  - ren == 0: no response pulse.
  - Disabled read ports capture 0.
  - rspN_rdata* hold their value until the next capture.
- Read/write to the same address in one transaction returns the pre-write value (regfile writes at the edge).
- Write to r0 is forwarded unchanged; the arbiter applies no r0 special case.
- clear_req in RUN:
  - The next cycle enters INIT (stays in RUN if INIT_EN=0); ready=0 from that cycle.
  - A transaction accepted in the same cycle as clear_req completes, including its rsp pulse.
- Synchronous reset mid-INIT restarts init_cnt at 0.
- Requesters must hold all request fields stable while valid && !ready.

Test Plan:
1. Release reset (INIT_EN=1) -> 32 cycles of rf_wen=F with rf_waddr 0..31 and rf_wdata=0; init_done rises on cycle 33; ready stays 0 during INIT even with req0_valid=1.
2. req0 write: we=1, be=F, waddr=5, wdata=0x12345678; then req0 read: raddr1=5, ren=01 -> rsp0_valid one cycle after accept, rsp0_rdata1=0x12345678, rsp0_rdata2=0.
3. req1 write to reg 5 with be=4'b0011, data 0xAABBCCDD; then read -> rsp1_rdata1=0x1234CCDD; rsp0_valid stays 0.
4. Both valid continuously after init -> grants req0, req1, req0, req1; each requester is granted exactly every other cycle.
5. Single transaction write reg 7 = 0x55 with read raddr2=7 -> rsp rdata2 returns the old value (0); a follow-up read returns 0x55.
6. clear_req during a req0 accept -> rsp0_valid still pulses; the next 32 cycles re-init all registers; a later read of reg 5 returns 0. Asserting resetn=0 at init_cnt=10 -> after release, the sequence restarts at waddr 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Purpose: shares the single write port and two read ports of the 32x32 register file between two requesters, using round-robin arbitration, and runs an INIT fill after reset or a clear.
// Latency: grant is combinational in the cycle of the request; read data is captured at the accepting edge and rspN_valid pulses one cycle later.
// Backpressure: reqN_ready is the grant, so a request is accepted on valid && ready; no grants are given during INIT or while resetn is low.
// Ports: clk/resetn (synchronous, active-low); clear_req/init_done; req0_*/req1_* request channels with
//        rsp0_*/rsp1_* response channels; rf_* drive the register file, and rf_rdata1/2 return its combinational read data.
module regfile_port_arbiter #(
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear_req,
    output logic        init_done,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [3:0]  req0_be,
    input  logic [1:0]  req0_ren,
    input  logic [4:0]  req0_raddr1,
    input  logic [4:0]  req0_raddr2,
    input  logic [4:0]  req0_waddr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata1,
    output logic [31:0] rsp0_rdata2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [3:0]  req1_be,
    input  logic [1:0]  req1_ren,
    input  logic [4:0]  req1_raddr1,
    input  logic [4:0]  req1_raddr2,
    input  logic [4:0]  req1_waddr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata1,
    output logic [31:0] rsp1_rdata2,

    output logic [3:0]  rf_wen,
    output logic [1:0]  rf_ren,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  init_cnt_q, init_cnt_d;
    logic        last_grant_q;          // 0 = req0 was granted last, 1 = req1
    logic        gnt0, gnt1;

    // The last values driven onto the regfile address/data lines; they are held there whenever nobody is granted.
    logic [4:0]  hold_raddr1_q, hold_raddr2_q, hold_waddr_q;
    logic [31:0] hold_wdata_q;

    assign init_done  = (state_q == ST_RUN);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rf_wen     = 4'h0;
        rf_ren     = 2'b00;
        rf_raddr1  = hold_raddr1_q;
        rf_raddr2  = hold_raddr2_q;
        rf_waddr   = hold_waddr_q;
        rf_wdata   = hold_wdata_q;

        if (resetn) begin
            case (state_q)
                ST_INIT: begin
                    rf_wen     = 4'hF;
                    rf_waddr   = init_cnt_q;
                    rf_wdata   = INIT_VALUE;
                    init_cnt_d = init_cnt_q + 5'd1;
                    if (init_cnt_q == 5'd31) begin
                        state_d    = ST_RUN;
                        init_cnt_d = 5'd0;
                    end
                end
                ST_RUN: begin
                    // On a tie, the requester that was not granted last wins.
                    gnt0 = req0_valid && (!req1_valid || last_grant_q);
                    gnt1 = req1_valid && (!req0_valid || !last_grant_q);
                    if (gnt0) begin
                        rf_ren    = req0_ren;
                        rf_wen    = req0_we ? req0_be : 4'h0;
                        rf_raddr1 = req0_raddr1;
                        rf_raddr2 = req0_raddr2;
                        rf_waddr  = req0_waddr;
                        rf_wdata  = req0_wdata;
                    end else if (gnt1) begin
                        rf_ren    = req1_ren;
                        rf_wen    = req1_we ? req1_be : 4'h0;
                        rf_raddr1 = req1_raddr1;
                        rf_raddr2 = req1_raddr2;
                        rf_waddr  = req1_waddr;
                        rf_wdata  = req1_wdata;
                    end
                    // A transaction granted in this same cycle still completes; only the following cycles are blocked.
                    if (clear_req && INIT_EN) begin
                        state_d = ST_INIT;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= INIT_EN ? ST_INIT : ST_RUN;
            init_cnt_q    <= 5'd0;
            last_grant_q  <= 1'b1;
            hold_raddr1_q <= 5'd0;
            hold_raddr2_q <= 5'd0;
            hold_waddr_q  <= 5'd0;
            hold_wdata_q  <= 32'd0;
            rsp0_valid    <= 1'b0;
            rsp0_rdata1   <= 32'd0;
            rsp0_rdata2   <= 32'd0;
            rsp1_valid    <= 1'b0;
            rsp1_rdata1   <= 32'd0;
            rsp1_rdata2   <= 32'd0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            hold_raddr1_q <= rf_raddr1;
            hold_raddr2_q <= rf_raddr2;
            hold_waddr_q  <= rf_waddr;
            hold_wdata_q  <= rf_wdata;
            if (gnt0 || gnt1) begin
                last_grant_q <= gnt1;
            end

            // The regfile reads combinationally, so the data on rf_rdata* here is the value from before this edge's write.
            rsp0_valid <= gnt0 && (req0_ren != 2'b00);
            if (gnt0 && (req0_ren != 2'b00)) begin
                rsp0_rdata1 <= req0_ren[0] ? rf_rdata1 : 32'd0;
                rsp0_rdata2 <= req0_ren[1] ? rf_rdata2 : 32'd0;
            end
            rsp1_valid <= gnt1 && (req1_ren != 2'b00);
            if (gnt1 && (req1_ren != 2'b00)) begin
                rsp1_rdata1 <= req1_ren[0] ? rf_rdata1 : 32'd0;
                rsp1_rdata2 <= req1_ren[1] ? rf_rdata2 : 32'd0;
            end
        end
    end

endmodule
